vx_tcu_tfr_norm_round_pipe: RTL and testbench
=============================================

// Module: VX_tcu_tfr_norm_round_pipe
// PURPOSE
//  Pipelined, multi-format normalise/round/pack stage at the tail of the TCU FEDP datapath.
//  Converts a two's-complement fixed-point accumulator plus a block exponent into an FP32,
//  FP16 or BF16 result, or a saturated INT32 result.
//  Rounding mode is selected per request, and RISC-V style exception flags are produced.
//  Uses a valid/ready handshake so the TCU writeback path can back-pressure it.
// PARAMETERS
//  WA        30  accumulator width, two's complement (>=27)
//  EXP_W     10  signed width of max_exp and internal exponent
//  TAG_W     32  request tag width, carried through unchanged
//  INT_EN    1   1: integer mode implemented; 0: is_int ignored, treated as FP
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-high reset
//  valid_in   in   1      input request valid
//  ready_in   out  1      block can accept input this cycle
//  tag_in     in   TAG_W  request tag
//  fmt        in   2      0=FP32, 1=FP16, 2=BF16, 3=reserved (treated as FP32)
//  rnd        in   2      0=RNE, 1=RTZ, 2=RDN, 3=RUP
//  is_int     in   1      integer result mode
//  max_exp    in   EXP_W  biased exponent (output-format bias) of accumulator bit WA-1
//  acc_sig    in   WA     signed accumulator
//  sticky_in  in   1      OR of bits lost upstream during alignment
//  exc_nan    in   1      upstream NaN / invalid operation
//  exc_inf    in   1      upstream infinity
//  exc_sign   in   1      sign of upstream infinity
//  valid_out  out  1      result valid
//  ready_out  in   1      consumer accepts result
//  tag_out    out  TAG_W  tag of result
//  result     out  32     packed result; 16-bit formats in [15:0], [31:16] all ones (NaN-boxed)
//  fflags     out  4      {NV, OF, UF, NX}
// BEHAVIOUR
//  Reset: all stage valid bits clear; valid_out=0, tag_out=0, result=0, fflags=0.
//    Reset mid-operation discards all in-flight requests.
//  Pipeline and handshake:
//  - Three register stages, latency 3 cycles with no stall:
//    S1 = abs value and exact LZC; S2 = shift; S3 = round, pack, flags.
//  - Global enable en = ~valid_out | ready_out. All stages advance only when en=1.
//  - ready_in = en. Bubbles are not collapsed.
//  - Results leave in strict input order.
//  - With valid_out=1 and ready_out=0, valid_out, tag_out, result and fflags hold stable.
//  Arithmetic:
//  - sign = acc_sig[WA-1]; mag = |acc_sig| computed in WA+1 bits, so the most negative value is exact.
//  - k = leading-zero count of mag over WA bits. The leading one then has exponent e = max_exp - k.
//  - Mantissa width M = 23, 10 or 7 for FP32, FP16 or BF16.
//    Max biased exponent EMAX = 254, 30 or 254.
//  - After normalising, the M bits following the leading one are kept.
//    G = next bit. S = OR of all lower bits OR sticky_in.
//  - Round-up condition by mode:
//    RNE: G & (S | lsb). RTZ: never. RDN: sign & (G|S). RUP: ~sign & (G|S).
//  - A mantissa carry-out increments e by 1 and shifts the mantissa right by 1.
//  - NX = G|S on any finite result.
//  Boundary cases:
//  - mag==0: result is +0, flags NX=sticky_in only.
//  - e<=0 after rounding: flush to signed zero, UF=1, NX=1.
//  - e>EMAX after rounding: OF=1, NX=1. RNE gives signed inf. RTZ gives signed max-finite.
//    RDN gives +max-finite / -inf. RUP gives +inf / -max-finite.
//  - exc_nan: canonical NaN (0x7FC00000, 0xFFFF7E00, 0xFFFF7FC0), NV=1, all other flags 0.
//  - exc_inf (with exc_nan=0): {exc_sign, all-ones exponent, 0 mantissa}, flags 0.
//  - exc_nan has priority over exc_inf, which has priority over arithmetic.
//  Integer mode (is_int=1, INT_EN=1):
//  - result = acc_sig sign-extended to 32 bits.
//  - If WA>32, saturate to 0x7FFFFFFF / 0x80000000 with OF=1.
//  - fmt, rnd and all exc_* inputs are ignored.
// TESTING
//  1. FP32 RNE, acc=30'h1, max_exp=156 -> 0x3F800000, fflags 0, valid_out exactly 3 cycles later.
//  2. FP32, acc=30'h3FFFFFFF, max_exp=156 -> 0xBF800000.
//     Same test with acc=30'h20000000 (most negative), max_exp=156 -> 0xCE000000.
//  3. FP32, acc=30'h02000002, max_exp=131, a G-only tie:
//     RNE -> 0x3F800000 NX; RTZ -> 0x3F800000 NX; RUP -> 0x3F800001 NX.
//  4. FP16, acc=30'h1, max_exp=60 (overflow):
//     RNE -> 0xFFFF7C00 {OF,NX}; RTZ -> 0xFFFF7BFF {OF,NX}.
//     Same with max_exp=29 -> 0xFFFF0000 {UF,NX}.
//  5. exc_nan=1, fmt=BF16 -> 0xFFFF7FC0 NV.
//     exc_inf=1, exc_sign=1, fmt=FP32 -> 0xFF800000.
//  6. Back-to-back stream of 8 requests; drop ready_out for 5 cycles mid-stream; assert reset once.
//     Required: ready_in low while stalled, no loss/duplication, tags in order.
//     Reset clears valid_out asynchronously.

Source files
------------

// File: rtl/vx_tcu_tfr_norm_round_pipe_if.sv
// Request/response bundle for the TCU FEDP normalise/round/pack stage.
//   Request side : valid_in/ready_in handshake, tag_in, fmt, rnd, is_int,
//                  max_exp, acc_sig, sticky_in, exc_nan, exc_inf, exc_sign.
//   Response side: valid_out/ready_out handshake, tag_out, result, fflags.
// The master modport is the producer of requests and consumer of results;
// the slave modport is the pipeline itself.
interface vx_tcu_tfr_norm_round_pipe_if #(
  parameter int WA    = 30,
  parameter int EXP_W = 10,
  parameter int TAG_W = 32
);
  logic                    valid_in;
  logic                    ready_in;
  logic [TAG_W-1:0]        tag_in;
  logic [1:0]              fmt;
  logic [1:0]              rnd;
  logic                    is_int;
  logic signed [EXP_W-1:0] max_exp;
  logic signed [WA-1:0]    acc_sig;
  logic                    sticky_in;
  logic                    exc_nan;
  logic                    exc_inf;
  logic                    exc_sign;
  logic                    valid_out;
  logic                    ready_out;
  logic [TAG_W-1:0]        tag_out;
  logic [31:0]             result;
  logic [3:0]              fflags;

  modport master (
    output valid_in, tag_in, fmt, rnd, is_int, max_exp, acc_sig,
           sticky_in, exc_nan, exc_inf, exc_sign, ready_out,
    input  ready_in, valid_out, tag_out, result, fflags
  );

  modport slave (
    input  valid_in, tag_in, fmt, rnd, is_int, max_exp, acc_sig,
           sticky_in, exc_nan, exc_inf, exc_sign, ready_out,
    output ready_in, valid_out, tag_out, result, fflags
  );
endinterface

// File: rtl/vx_tcu_tfr_norm_round_pipe.sv
// Three-stage normalise/round/pack pipeline at the tail of the TCU FEDP path.
// Turns a two's-complement fixed-point accumulator plus block exponent into an
// FP32, FP16 or BF16 value (16-bit results NaN-boxed), or a saturated INT32,
// with {NV, OF, UF, NX} flags. One global enable stalls every stage when the
// output is held, so results leave in order and bubbles are kept.
// Ports:
//   clk   - clock
//   reset - asynchronous, active-high; drops all in-flight requests
//   io    - request/response bundle (slave side), see the interface file
module vx_tcu_tfr_norm_round_pipe #(
  parameter int WA     = 30,
  parameter int EXP_W  = 10,
  parameter int TAG_W  = 32,
  parameter int INT_EN = 1
) (
  input  logic clk,
  input  logic reset,
  vx_tcu_tfr_norm_round_pipe_if.slave io
);
  localparam int LZ_W = $clog2(WA + 1);
  localparam int EW   = EXP_W + 2;
  localparam logic [WA-2:0] ONES = '1;

  logic en;
  assign en          = ~io.valid_out | io.ready_out;
  assign io.ready_in = en;

  function automatic logic [LZ_W-1:0] lzc(input logic [WA-1:0] v);
    logic [LZ_W-1:0] n;
    n = LZ_W'(WA);
    for (int i = 0; i < WA; i++)
      if (v[i]) n = LZ_W'(WA - 1 - i);
    return n;
  endfunction

  function automatic logic round_up(input logic [1:0] mode, input logic sign,
                                    input logic lsb, input logic g, input logic s);
    case (mode)
      2'd0:    return g & (s | lsb);
      2'd1:    return 1'b0;
      2'd2:    return sign & (g | s);
      default: return ~sign & (g | s);
    endcase
  endfunction

  // Overflow goes to infinity only when rounding away from zero in that direction.
  function automatic logic ovf_to_inf(input logic [1:0] mode, input logic sign);
    case (mode)
      2'd0:    return 1'b1;
      2'd1:    return 1'b0;
      2'd2:    return sign;
      default: return ~sign;
    endcase
  endfunction

  function automatic logic [31:0] pack(input logic [1:0] f, input logic sign,
                                       input logic [7:0] ex, input logic [22:0] man);
    case (f)
      2'd1:    return {16'hFFFF, sign, ex[4:0], man[9:0]};
      2'd2:    return {16'hFFFF, sign, ex, man[6:0]};
      default: return {sign, ex, man};
    endcase
  endfunction

  // Returns {overflow, value}; only wide accumulators can exceed INT32.
  function automatic logic [32:0] int_sat(input logic signed [WA-1:0] a);
    logic signed [WA+31:0] w;
    w = {{32{a[WA-1]}}, a};
    if (w > $signed({{WA{1'b0}}, 32'h7FFF_FFFF}))      return {1'b1, 32'h7FFF_FFFF};
    else if (w < $signed({{WA{1'b1}}, 32'h8000_0000})) return {1'b1, 32'h8000_0000};
    else                                               return {1'b0, w[31:0]};
  endfunction

  // ---- stage 1: sign, magnitude (WA+1 bits so -2^(WA-1) is exact), LZC ----
  logic                    sign_s0;
  logic [WA:0]             mag_wide;
  logic [WA-1:0]           mag_s0;
  assign sign_s0  = io.acc_sig[WA-1];
  assign mag_wide = sign_s0 ? -{io.acc_sig[WA-1], io.acc_sig} : {io.acc_sig[WA-1], io.acc_sig};
  assign mag_s0   = WA'(mag_wide);

  logic                    vld_p0, sign_p0, is_int_p0, sticky_p0, nan_p0, inf_p0, isign_p0;
  logic [TAG_W-1:0]        tag_p0;
  logic [1:0]              fmt_p0, rnd_p0;
  logic signed [EXP_W-1:0] max_exp_p0;
  logic signed [WA-1:0]    acc_p0;
  logic [WA-1:0]           mag_p0;
  logic [LZ_W-1:0]         lz_p0;

  always_ff @(posedge clk) begin
    if (en) begin
      sign_p0    <= sign_s0;
      mag_p0     <= mag_s0;
      lz_p0      <= lzc(mag_s0);
      max_exp_p0 <= io.max_exp;
      acc_p0     <= io.acc_sig;
      is_int_p0  <= (INT_EN != 0) && io.is_int;
      fmt_p0     <= io.fmt;
      rnd_p0     <= io.rnd;
      sticky_p0  <= io.sticky_in;
      nan_p0     <= io.exc_nan;
      inf_p0     <= io.exc_inf;
      isign_p0   <= io.exc_sign;
      tag_p0     <= io.tag_in;
    end
  end

  // ---- stage 2: normalise so the leading one sits at bit WA-1 ----
  logic                    vld_p1, sign_p1, is_int_p1, sticky_p1, nan_p1, inf_p1, isign_p1, zero_p1;
  logic [TAG_W-1:0]        tag_p1;
  logic [1:0]              fmt_p1, rnd_p1;
  logic signed [WA-1:0]    acc_p1;
  logic [WA-1:0]           norm_p1;
  logic signed [EW-1:0]    exp_p1;

  always_ff @(posedge clk) begin
    if (en) begin
      norm_p1   <= mag_p0 << lz_p0;
      exp_p1    <= EW'(max_exp_p0) - EW'(lz_p0);
      zero_p1   <= (mag_p0 == '0);
      sign_p1   <= sign_p0;
      acc_p1    <= acc_p0;
      is_int_p1 <= is_int_p0;
      fmt_p1    <= fmt_p0;
      rnd_p1    <= rnd_p0;
      sticky_p1 <= sticky_p0;
      nan_p1    <= nan_p0;
      inf_p1    <= inf_p0;
      isign_p1  <= isign_p0;
      tag_p1    <= tag_p0;
    end
  end

  // ---- stage 3: round, pack, flags ----
  int                   mw;
  logic signed [EW-1:0] emax;
  logic [WA-2:0]        frac;
  logic [22:0]          man;
  logic                 g, s, up, carry;
  logic [23:0]          man_r;
  logic signed [EW-1:0] exp_r;
  logic [32:0]          int_r;
  logic [31:0]          res_d;
  logic [3:0]           ff_d;

  always_comb begin
    mw   = 23;
    emax = EW'(254);
    case (fmt_p1)
      2'd1:    begin mw = 10; emax = EW'(30);  end
      2'd2:    begin mw = 7;  emax = EW'(254); end
      default: begin mw = 23; emax = EW'(254); end
    endcase
    // Bits below the implicit leading one; mantissa is right-aligned in man.
    frac  = (WA-1)'(norm_p1);
    man   = 23'(frac >> (WA - 1 - mw));
    g     = frac[WA-2-mw];
    s     = (|(frac & (ONES >> (mw + 1)))) | sticky_p1;
    up    = round_up(rnd_p1, sign_p1, man[0], g, s);
    man_r = {1'b0, man} + 24'(up);
    // On carry-out the kept bits are already zero: mantissa 1.000.. at e+1.
    carry = man_r[mw];
    exp_r = exp_p1 + EW'(carry);
    int_r = int_sat(acc_p1);
    res_d = '0;
    ff_d  = '0;
    if (is_int_p1) begin
      res_d = int_r[31:0];
      ff_d  = {1'b0, int_r[32], 2'b00};
    end else if (nan_p1) begin
      case (fmt_p1)
        2'd1:    res_d = 32'hFFFF_7E00;
        2'd2:    res_d = 32'hFFFF_7FC0;
        default: res_d = 32'h7FC0_0000;
      endcase
      ff_d = 4'b1000;
    end else if (inf_p1) begin
      res_d = pack(fmt_p1, isign_p1, 8'hFF, 23'd0);
    end else if (zero_p1) begin
      res_d = pack(fmt_p1, 1'b0, 8'h00, 23'd0);
      ff_d  = {3'b000, sticky_p1};
    end else if (exp_r <= 0) begin
      res_d = pack(fmt_p1, sign_p1, 8'h00, 23'd0);
      ff_d  = 4'b0011;
    end else if (exp_r > emax) begin
      res_d = ovf_to_inf(rnd_p1, sign_p1) ? pack(fmt_p1, sign_p1, 8'hFF, 23'd0)
                                          : pack(fmt_p1, sign_p1, 8'(emax), 23'h7F_FFFF);
      ff_d  = 4'b0101;
    end else begin
      res_d = pack(fmt_p1, sign_p1, 8'(exp_r), man_r[22:0]);
      ff_d  = {3'b000, g | s};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      io.valid_out <= 1'b0;
      io.tag_out   <= '0;
      io.result    <= '0;
      io.fflags    <= '0;
    end else if (en) begin
      vld_p0       <= io.valid_in;
      vld_p1       <= vld_p0;
      io.valid_out <= vld_p1;
      io.tag_out   <= tag_p1;
      io.result    <= res_d;
      io.fflags    <= ff_d;
    end
  end
endmodule

// File: tb/tb_vx_tcu_tfr_norm_round_pipe.sv
`timescale 1ns/1ps
module tb_vx_tcu_tfr_norm_round_pipe;
  localparam int WA = 30, EXP_W = 10, TAG_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_tcu_tfr_norm_round_pipe_if #(.WA(WA), .EXP_W(EXP_W), .TAG_W(TAG_W)) bus ();
  vx_tcu_tfr_norm_round_pipe #(.WA(WA), .EXP_W(EXP_W), .TAG_W(TAG_W), .INT_EN(1)) dut (
    .clk(clk), .reset(reset), .io(bus)
  );

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic [3:0]       ff;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0, n_fail = 0, n_out = 0, n_sent = 0, n_dropped = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer, and checks hold stability.
  exp_t             m_e;
  logic             prev_stall = 1'b0;
  logic [TAG_W-1:0] prev_tag;
  logic [31:0]      prev_res;
  logic [3:0]       prev_ff;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_vld", 64'(bus.valid_out), 64'd1);
          check("hold_data", {bus.tag_out, bus.result, bus.fflags}, {prev_tag, prev_res, prev_ff});
        end
        if (bus.valid_out && bus.ready_out) begin
          if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_out: tag %h result %h, expected no output", bus.tag_out, bus.result);
          end else begin
            m_e = sb_q.pop_front();
            n_out++;
            check($sformatf("tag[%h]", m_e.tag), 64'(bus.tag_out), 64'(m_e.tag));
            check($sformatf("result[%h]", m_e.tag), 64'(bus.result), 64'(m_e.res));
            check($sformatf("fflags[%h]", m_e.tag), 64'(bus.fflags), 64'(m_e.ff));
          end
        end
        prev_stall = bus.valid_out && !bus.ready_out;
        prev_tag   = bus.tag_out;
        prev_res   = bus.result;
        prev_ff    = bus.fflags;
      end
    end
  end

  // Drive one request starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [31:0] tag, input logic [1:0] fmt, input logic [1:0] rnd,
                      input logic is_int, input logic [9:0] me, input logic [29:0] acc,
                      input logic sticky, input logic nan, input logic inf, input logic isign,
                      input logic [31:0] eres, input logic [3:0] eff);
    int   budget;
    logic ok;
    bus.valid_in  = 1'b1;
    bus.tag_in    = tag;
    bus.fmt       = fmt;
    bus.rnd       = rnd;
    bus.is_int    = is_int;
    bus.max_exp   = me;
    bus.acc_sig   = acc;
    bus.sticky_in = sticky;
    bus.exc_nan   = nan;
    bus.exc_inf   = inf;
    bus.exc_sign  = isign;
    budget = 0;
    ok     = 1'b0;
    while (!ok && budget < 50) begin
      @(negedge clk);
      ok = bus.ready_in;
      if (ok) begin
        sb_q.push_back('{tag: tag, res: eres, ff: eff});
        n_sent++;
      end
      @(posedge clk); #1;
      budget++;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: tag %h not accepted, expected acceptance within 50 cycles", tag);
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb_q.size() != 0 && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    if (sb_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200us");
    $fatal(1, "watchdog");
  end

  int cnt;
  initial begin
    reset = 1'b1;
    bus.valid_in = 1'b0; bus.tag_in = '0; bus.fmt = '0; bus.rnd = '0; bus.is_int = 1'b0;
    bus.max_exp = '0; bus.acc_sig = '0; bus.sticky_in = 1'b0; bus.exc_nan = 1'b0;
    bus.exc_inf = 1'b0; bus.exc_sign = 1'b0; bus.ready_out = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_out", 64'(bus.valid_out), 64'd0);
    check("reset_tag_out", 64'(bus.tag_out), 64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_fflags", 64'(bus.fflags), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency: valid_out appears on the third rising edge after presentation.
    send(32'h1, 2'd0, 2'd0, 1'b0, 10'd156, 30'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0000);
    bus.valid_in = 1'b0;
    cnt = 1;
    while (!bus.valid_out && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", 64'(cnt), 64'd3);
    drain();

    //   tag          fmt   rnd   int   max_exp  acc            stk   nan   inf   sgn   result         {NV,OF,UF,NX}
    send(32'h10, 2'd0, 2'd0, 1'b0, 10'd156, 30'h3FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hBF80_0000, 4'b0000);
    send(32'h11, 2'd0, 2'd0, 1'b0, 10'd156, 30'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hCE00_0000, 4'b0000);
    send(32'h12, 2'd0, 2'd0, 1'b0, 10'd131, 30'h0200_0002, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0001);
    send(32'h13, 2'd0, 2'd1, 1'b0, 10'd131, 30'h0200_0002, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0001);
    send(32'h14, 2'd0, 2'd3, 1'b0, 10'd131, 30'h0200_0002, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0001, 4'b0001);
    send(32'h15, 2'd0, 2'd2, 1'b0, 10'd131, 30'h3DFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32'hBF80_0001, 4'b0001);
    send(32'h16, 2'd1, 2'd0, 1'b0, 10'd60,  30'h1,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_7C00, 4'b0101);
    send(32'h17, 2'd1, 2'd1, 1'b0, 10'd60,  30'h1,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_7BFF, 4'b0101);
    send(32'h18, 2'd1, 2'd2, 1'b0, 10'd60,  30'h1,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_7BFF, 4'b0101);
    send(32'h19, 2'd1, 2'd2, 1'b0, 10'd60,  30'h3FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FC00, 4'b0101);
    send(32'h1A, 2'd1, 2'd3, 1'b0, 10'd60,  30'h1,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_7C00, 4'b0101);
    send(32'h1B, 2'd1, 2'd0, 1'b0, 10'd29,  30'h1,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 4'b0011);
    send(32'h1C, 2'd0, 2'd0, 1'b0, 10'd29,  30'h3FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b0011);
    send(32'h1D, 2'd1, 2'd0, 1'b0, 10'd44,  30'h1,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_3C00, 4'b0000);
    send(32'h1E, 2'd2, 2'd0, 1'b0, 10'd156, 30'h3,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_4040, 4'b0000);
    send(32'h1F, 2'd2, 2'd0, 1'b0, 10'd156, 30'h1FF,       1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_4400, 4'b0001);
    send(32'h20, 2'd3, 2'd0, 1'b0, 10'd156, 30'h1,         1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0000);
    send(32'h21, 2'd0, 2'd0, 1'b0, 10'd156, 30'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0001);
    send(32'h22, 2'd1, 2'd0, 1'b0, 10'd156, 30'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_0000, 4'b0000);
    send(32'h23, 2'd2, 2'd0, 1'b0, 10'd156, 30'h1,         1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_7FC0, 4'b1000);
    send(32'h24, 2'd0, 2'd0, 1'b0, 10'd156, 30'h1,         1'b0, 1'b1, 1'b1, 1'b1, 32'h7FC0_0000, 4'b1000);
    send(32'h25, 2'd1, 2'd0, 1'b0, 10'd156, 30'h1,         1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_7E00, 4'b1000);
    send(32'h26, 2'd0, 2'd0, 1'b0, 10'd156, 30'h1,         1'b0, 1'b0, 1'b1, 1'b1, 32'hFF80_0000, 4'b0000);
    send(32'h27, 2'd1, 2'd0, 1'b0, 10'd156, 30'h1,         1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_7C00, 4'b0000);
    send(32'h28, 2'd1, 2'd3, 1'b1, 10'd156, 30'h2000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hE000_0000, 4'b0000);
    send(32'h29, 2'd2, 2'd0, 1'b1, 10'd0,   30'h1FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1FFF_FFFF, 4'b0000);
    bus.valid_in = 1'b0;
    drain();

    // Back-to-back stream with a 5-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [29:0] a;
          a = 30'd1 << i;
          send(32'h100 + 32'(i), 2'd0, 2'd0, 1'b0, 10'd156, a, 1'b0, 1'b0, 1'b0, 1'b0,
               32'h3F80_0000 + (32'(i) << 23), 4'b0000);
        end
        bus.valid_in = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 bus.ready_out = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("stall_valid_out", 64'(bus.valid_out), 64'd1);
          check("stall_ready_in", 64'(bus.ready_in), 64'd0);
        end
        @(posedge clk);
        #1 bus.ready_out = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with requests in flight.
    send(32'h200, 2'd0, 2'd0, 1'b0, 10'd156, 30'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 4'b0000);
    send(32'h201, 2'd0, 2'd0, 1'b0, 10'd156, 30'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 4'b0000);
    send(32'h202, 2'd0, 2'd0, 1'b0, 10'd156, 30'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4080_0000, 4'b0000);
    bus.valid_in = 1'b0;
    check("pre_reset_valid_out", 64'(bus.valid_out), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid_out", 64'(bus.valid_out), 64'd0);
    check("async_reset_tag_out", 64'(bus.tag_out), 64'd0);
    check("async_reset_result", 64'(bus.result), 64'd0);
    check("async_reset_fflags", 64'(bus.fflags), 64'd0);
    n_dropped = sb_q.size();
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    send(32'h300, 2'd1, 2'd0, 1'b0, 10'd44, 30'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_3C00, 4'b0000);
    bus.valid_in = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("output_count", 64'(n_out), 64'(n_sent - n_dropped));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
